// File: rtl/fetch_ctrl_if.sv
// Instruction-memory bus and fetch-to-decode handshake of fetch_ctrl.
// The master side is the fetch controller; the slave side is memory plus decode.
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_instr,
        input  imem_ack, imem_rdata, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_instr,
        output imem_ack, imem_rdata, if_ready
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding request, redirect squash via a kill flag.
// Optional FETCH_STALL_CNT_EN adds stall_cnt, counting cycles a request waits for its ack.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redir_valid,
    input  logic [1:0]  redir_op,
    input  logic [31:0] redir_pc,
    input  logic [25:0] redir_imm,
    output logic [31:0] npc_pc,
    output logic [1:0]  npc_op,
    output logic [25:0] npc_imm,
    input  logic [31:0] npc,
`ifdef FETCH_STALL_CNT_EN
    output logic [31:0] stall_cnt,
`endif
    fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    localparam logic [1:0] OP_PLUS4  = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_JUMP   = 2'b10;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_addr;
    logic        kill;
    logic        req_on;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        release_hold;

    assign bus.imem_req  = req_on;
    assign bus.imem_addr = req_addr;
    assign bus.if_valid  = out_valid;
    assign bus.if_pc     = out_pc;
    assign bus.if_instr  = out_instr;

    assign release_hold = bus.if_ready && !stall;

    // The next-PC unit is shared: a redirect borrows it, otherwise it computes req_addr + 4.
    always_comb begin
        // NOTE: every output gets a default first, so no path through this block infers a latch.
        npc_pc  = req_addr;
        npc_op  = OP_PLUS4;
        npc_imm = '0;
        if (redir_valid) begin
            npc_pc  = redir_pc;
            npc_op  = (redir_op == OP_BRANCH) ? OP_BRANCH : OP_JUMP;
            npc_imm = redir_imm;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            kill      <= 1'b0;
            req_on    <= 1'b0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_instr <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every branch below reads pre-edge register values.
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    req_on   <= 1'b1;
                    req_addr <= redir_valid ? npc : pc;
                    if (redir_valid) pc <= npc;
                end

                FETCH: begin
                    if (redir_valid) begin
                        pc <= npc;
                        if (bus.imem_ack) begin
                            kill     <= 1'b0;
                            req_addr <= npc;
                        end else begin
                            // The in-flight response belongs to the old path; drop it when it lands.
                            kill <= 1'b1;
                        end
                    end else if (bus.imem_ack) begin
                        if (kill) begin
                            kill     <= 1'b0;
                            req_addr <= pc;
                        end else begin
                            out_valid <= 1'b1;
                            out_pc    <= req_addr;
                            out_instr <= bus.imem_rdata;
                            pc        <= npc;
                            req_on    <= 1'b0;
                            state     <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    if (redir_valid || release_hold) begin
                        out_valid <= 1'b0;
                        req_on    <= 1'b1;
                        state     <= FETCH;
                        req_addr  <= redir_valid ? npc : pc;
                        if (redir_valid) pc <= npc;
                    end
                end

                default: begin
                    state  <= IDLE;
                    req_on <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (req_on && !bus.imem_ack) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif
endmodule
